// File: rtl/gpio_irq.sv
// Wishbone-classic GPIO slave: byte-enabled output register with atomic set/clear,
// synchronised inputs and per-pin rising/falling edge interrupts with W1C status.
module gpio_irq #(
  parameter int GPOCNT      = 1,
  parameter int GPICNT      = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [2:0]        adr_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       dat_i,
  output logic [31:0]       dat_o,
  output logic              ack_o,
  input  logic [GPICNT-1:0] gpi_i,
  output logic [GPOCNT-1:0] gpo_o,
  output logic              irq_o
);

  localparam logic [2:0] PRIME_END = 3'(SYNC_STAGES + 1);

  logic              req, wr;
  logic [31:0]       mask, wdat, rdata;
  logic [31:0]       gpo32, gpi32, ien32, rise32, fall32, stat32;
  logic [31:0]       gpo_n, ien_n, rise_n, fall_n, stat_n, clr32, evt32;
  logic [GPOCNT-1:0] gpo;
  logic [GPICNT-1:0] ien, rise, fall, stat;
  logic [GPICNT-1:0] sync_q [SYNC_STAGES];
  logic [GPICNT-1:0] gpi_s, gpi_q, evt;
  logic [2:0]        prime_cnt;
  logic              primed;
  logic              unused_ok;

  assign req    = cyc_i & stb_i & ~ack_o;
  assign wr     = req & we_i;
  assign gpi_s  = sync_q[SYNC_STAGES-1];
  assign primed = (prime_cnt == PRIME_END);
  assign gpo_o  = gpo;
  assign evt    = primed ? ((rise & gpi_s & ~gpi_q) | (fall & ~gpi_s & gpi_q)) : '0;

  // Registers are zero-extended to the 32-bit bus so unimplemented bits read 0
  // and the upper bits of every merged write value are simply dropped.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) mask[8*i +: 8] = {8{be_i[i]}};
    wdat   = dat_i & mask;
    gpo32  = '0; gpo32[GPOCNT-1:0]  = gpo;
    gpi32  = '0; gpi32[GPICNT-1:0]  = gpi_s;
    ien32  = '0; ien32[GPICNT-1:0]  = ien;
    rise32 = '0; rise32[GPICNT-1:0] = rise;
    fall32 = '0; fall32[GPICNT-1:0] = fall;
    stat32 = '0; stat32[GPICNT-1:0] = stat;
    evt32  = '0; evt32[GPICNT-1:0]  = evt;
  end

  always_comb begin
    gpo_n  = gpo32;
    ien_n  = ien32;
    rise_n = rise32;
    fall_n = fall32;
    clr32  = '0;
    if (wr) begin
      case (adr_i)
        3'd0:    gpo_n  = (gpo32 & ~mask) | wdat;
        3'd2:    ien_n  = (ien32 & ~mask) | wdat;
        3'd3:    rise_n = (rise32 & ~mask) | wdat;
        3'd4:    fall_n = (fall32 & ~mask) | wdat;
        3'd5:    clr32  = wdat;
        3'd6:    gpo_n  = gpo32 | wdat;
        3'd7:    gpo_n  = gpo32 & ~wdat;
        default: ;
      endcase
    end
    // A fresh event overrides a simultaneous clear of the same bit.
    stat_n = (stat32 & ~clr32) | evt32;
  end

  always_comb begin
    rdata = '0;
    case (adr_i)
      3'd0:    rdata = gpo32;
      3'd1:    rdata = gpi32;
      3'd2:    rdata = ien32;
      3'd3:    rdata = rise32;
      3'd4:    rdata = fall32;
      3'd5:    rdata = stat32;
      default: rdata = '0;
    endcase
  end

  assign unused_ok = ^{gpo_n, ien_n, rise_n, fall_n, stat_n};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o     <= 1'b0;
      dat_o     <= '0;
      irq_o     <= 1'b0;
      gpo       <= '0;
      ien       <= '0;
      rise      <= '0;
      fall      <= '0;
      stat      <= '0;
      gpi_q     <= '0;
      prime_cnt <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      ack_o <= req;
      dat_o <= (req & ~we_i) ? rdata : '0;
      irq_o <= |(stat & ien);
      gpo   <= gpo_n[GPOCNT-1:0];
      ien   <= ien_n[GPICNT-1:0];
      rise  <= rise_n[GPICNT-1:0];
      fall  <= fall_n[GPICNT-1:0];
      stat  <= stat_n[GPICNT-1:0];
      gpi_q <= gpi_s;
      if (!primed) prime_cnt <= prime_cnt + 3'd1;
      sync_q[0] <= gpi_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

endmodule

// File: tb/tb_gpio_irq.sv
// Scoreboard bench for gpio_irq: expected read data is queued when a request is
// issued and compared when ack_o returns.
module tb_gpio_irq;
  localparam int SYNC = 2;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [2:0]  adr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0, rdata, gpi = '1, gpo;
  logic        ack, irq;

  int n_checks = 0, n_fail = 0;

  typedef struct { bit rd; logic [31:0] exp; string tag; } txn_t;
  txn_t sb[$];

  gpio_irq #(.GPOCNT(32), .GPICNT(32), .SYNC_STAGES(SYNC)) dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .adr_i(adr), .be_i(be), .dat_i(wdata), .dat_o(rdata), .ack_o(ack),
    .gpi_i(gpi), .gpo_o(gpo), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ack) begin
      if (sb.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
      else begin
        txn_t t;
        t = sb.pop_front();
        if (t.rd) check(t.tag, rdata, t.exp);
      end
    end
  end

  task automatic bus_start(input bit w, input logic [2:0] a, input logic [3:0] b,
                           input logic [31:0] d, input logic [31:0] exp, input string tag);
    txn_t t;
    t.rd = !w; t.exp = exp; t.tag = tag;
    sb.push_back(t);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; be = b; wdata = d;
  endtask

  task automatic bus_finish();
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 16);
    if (!ack) check("ack_timeout", 32'd0, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] b, input logic [31:0] d);
    @(posedge clk); #1;
    bus_start(1'b1, a, b, d, '0, "write");
    bus_finish();
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    @(posedge clk); #1;
    bus_start(1'b0, a, 4'hF, '0, exp, tag);
    bus_finish();
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // RISE=all is queued during reset so it lands on the first edge after release.
    bus_start(1'b1, 3'd3, 4'hF, 32'hFFFF_FFFF, '0, "rise_all");
    wait_clk(3);
    check("rst_gpo", gpo, 32'h0);
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_dat", rdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    bus_finish();
    wr(3'd2, 4'hF, 32'hFFFF_FFFF);
    wait_clk(4);
    rd(3'd5, 32'h0, "prime_stat");
    wait_clk(1);
    check("prime_irq", {31'b0, irq}, 32'h0);
    wr(3'd2, 4'hF, 32'h0);
    wr(3'd3, 4'hF, 32'h0);

    wr(3'd0, 4'b0011, 32'hA5A5_A5A5);
    check("gpo_be", gpo, 32'h0000_A5A5);
    rd(3'd0, 32'h0000_A5A5, "gpo_rd");
    wr(3'd6, 4'hF, 32'h1);
    rd(3'd0, 32'h0000_A5A5, "gposet_rd");
    wr(3'd7, 4'b0001, 32'hFFFF_0005);
    rd(3'd0, 32'h0000_A5A0, "gpoclr_rd");
    wr(3'd6, 4'b0000, 32'hFFFF_FFFF);
    check("gposet_nobe", gpo, 32'h0000_A5A0);
    wr(3'd1, 4'hF, 32'h0);
    rd(3'd7, 32'h0, "wo_rd");

    gpi[3] = 1'b0;
    wait_clk(6);
    wr(3'd3, 4'hF, 32'h8);
    wr(3'd2, 4'hF, 32'h8);
    gpi[3] = 1'b1;
    wait_clk(SYNC + 1);
    check("rise_irq_early", {31'b0, irq}, 32'h0);
    wait_clk(1);
    check("rise_irq", {31'b0, irq}, 32'h1);
    rd(3'd5, 32'h8, "rise_stat");
    rd(3'd1, 32'hFFFF_FFFF, "gpi_rd");
    wr(3'd5, 4'h1, 32'h8);
    rd(3'd5, 32'h0, "w1c_stat");
    check("w1c_irq", {31'b0, irq}, 32'h0);

    wr(3'd2, 4'hF, 32'h0);
    wr(3'd4, 4'hF, 32'h1);
    gpi[0] = 1'b0;
    wait_clk(6);
    rd(3'd5, 32'h1, "fall_stat");
    check("fall_irq_masked", {31'b0, irq}, 32'h0);
    wr(3'd2, 4'hF, 32'h1);
    wait_clk(1);
    check("fall_irq_en", {31'b0, irq}, 32'h1);
    wr(3'd5, 4'hF, 32'h1);
    wr(3'd2, 4'hF, 32'h8);

    gpi[3] = 1'b0;
    wait_clk(6);
    gpi[3] = 1'b1;
    wait_clk(6);
    rd(3'd5, 32'h8, "pre_race_stat");
    gpi[3] = 1'b0;
    wait_clk(6);
    gpi[3] = 1'b1;
    wait_clk(2);
    bus_start(1'b1, 3'd5, 4'hF, 32'h8, '0, "race_w1c");
    bus_finish();
    rd(3'd5, 32'h8, "race_stat");
    wr(3'd5, 4'hF, 32'h8);
    rd(3'd5, 32'h0, "race_clear");

    @(posedge clk); #1;
    bus_start(1'b0, 3'd1, 4'hF, '0, 32'hFFFF_FFFE, "b2b_rd0");
    check("b2b_ack0", {31'b0, ack}, 32'h0);
    @(posedge clk); #1;
    check("b2b_ack1", {31'b0, ack}, 32'h1);
    bus_start(1'b0, 3'd1, 4'hF, '0, 32'hFFFF_FFFE, "b2b_rd1");
    @(posedge clk); #1;
    check("b2b_ack2", {31'b0, ack}, 32'h0);
    @(posedge clk); #1;
    check("b2b_ack3", {31'b0, ack}, 32'h1);
    cyc = 1'b0; stb = 1'b0;

    wait_clk(3);
    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
